// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the countdown timer: the two-state FSM encoding used
// by countdown_timer.
// -----------------------------------------------------------------------------
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_e;

endpackage : timer_pkg

// File: rtl/timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// Free-running divider that produces one tick every limit_i+1 enabled cycles.
//
// Ports:
//   clk_i    : clock, all state on rising edge
//   reset_i  : synchronous active-high reset
//   clr_i    : synchronous clear of the divider count (wins over en_i)
//   en_i     : count enable
//   limit_i  : terminal value; the count wraps to 0 after reaching it
//   tick_o   : high in the cycle where the count equals limit_i while enabled
// -----------------------------------------------------------------------------
module timer_prescaler #(
  parameter int PRE_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [PRE_WIDTH-1:0] limit_i,
  output logic                 tick_o
);

  logic [PRE_WIDTH-1:0] cnt_q;
  logic [PRE_WIDTH-1:0] cnt_d;
  logic                 at_limit;

  assign at_limit = (cnt_q == limit_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_limit ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A clear in the same cycle suppresses the tick so a stop can never be
  // followed by a decrement.
  assign tick_o = en_i && !clr_i && at_limit;

endmodule : timer_prescaler

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// Loadable down-counter with prescaler, optional auto-reload and abort.
// A load is accepted in IDLE; the count then decrements once per prescaler
// tick. When a tick hits count 1, expired_o pulses for one cycle and the
// counter either reloads (auto mode) or returns to IDLE with count 0.
//
// Ports:
//   clk_i, reset_i : clock and synchronous active-high reset
//   load_valid_i   : load request
//   load_ready_o   : high in IDLE (load can be accepted)
//   load_value_i   : start count, sampled on handshake
//   reload_i       : auto-reload mode, sampled on handshake
//   prescale_i     : tick every prescale_i+1 cycles, sampled on handshake
//   stop_i         : abort a running countdown (holds count, no pulse)
//   count_o        : current remaining count
//   busy_o         : high in RUN
//   expired_o      : one-cycle pulse at terminal count
// -----------------------------------------------------------------------------
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int PRE_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 load_valid_i,
  output logic                 load_ready_o,
  input  logic [WIDTH-1:0]     load_value_i,
  input  logic                 reload_i,
  input  logic [PRE_WIDTH-1:0] prescale_i,
  input  logic                 stop_i,
  output logic [WIDTH-1:0]     count_o,
  output logic                 busy_o,
  output logic                 expired_o
);

  timer_state_e         state_q,    state_d;
  logic [WIDTH-1:0]     count_q,    count_d;
  logic [WIDTH-1:0]     reload_q,   reload_d;
  logic                 auto_q,     auto_d;
  logic [PRE_WIDTH-1:0] prescale_q, prescale_d;
  logic                 expired_q,  expired_d;

  logic handshake;
  logic stop_run;
  logic pre_clr;
  logic pre_en;
  logic tick;

  assign handshake = load_valid_i && (state_q == IDLE);
  assign stop_run  = stop_i && (state_q == RUN);

  // The divider restarts on every new load and on abort so the next run
  // always sees a full first period.
  assign pre_clr = handshake || stop_run;
  assign pre_en  = (state_q == RUN);

  timer_prescaler #(
    .PRE_WIDTH (PRE_WIDTH)
  ) u_prescaler (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (pre_clr),
    .en_i    (pre_en),
    .limit_i (prescale_q),
    .tick_o  (tick)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    auto_d     = auto_q;
    prescale_d = prescale_q;
    expired_d  = 1'b0;

    if (state_q == IDLE) begin
      if (handshake) begin
        count_d    = load_value_i;
        reload_d   = load_value_i;
        auto_d     = reload_i;
        prescale_d = prescale_i;
        // A zero load expires immediately without ever entering RUN.
        if (load_value_i == '0) begin
          expired_d = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
    end else begin
      if (stop_i) begin
        // Abort wins over a coincident tick: count is frozen as-is.
        state_d = IDLE;
      end else if (tick) begin
        if (count_q == WIDTH'(1)) begin
          expired_d = 1'b1;
          if (auto_q) begin
            count_d = reload_q;
          end else begin
            count_d = '0;
            state_d = IDLE;
          end
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      count_q    <= '0;
      reload_q   <= '0;
      auto_q     <= 1'b0;
      prescale_q <= '0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      auto_q     <= auto_d;
      prescale_q <= prescale_d;
      expired_q  <= expired_d;
    end
  end

  assign count_o      = count_q;
  assign expired_o    = expired_q;
  assign busy_o       = (state_q == RUN);
  assign load_ready_o = (state_q == IDLE);

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
// Directed stimulus for countdown_timer (WIDTH=4). Each scenario pushes its
// expected snapshots (count/busy/ready at a given cycle) and expected expiry
// cycles into queues; a negedge monitor pops and compares them against the
// DUT, and flags any expired_o pulse nobody asked for.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

  localparam int WIDTH     = 4;
  localparam int PRE_WIDTH = 8;

  logic                 clk_i = 1'b0;
  logic                 reset_i;
  logic                 load_valid_i;
  logic                 load_ready_o;
  logic [WIDTH-1:0]     load_value_i;
  logic                 reload_i;
  logic [PRE_WIDTH-1:0] prescale_i;
  logic                 stop_i;
  logic [WIDTH-1:0]     count_o;
  logic                 busy_o;
  logic                 expired_o;

  always #5 clk_i = ~clk_i;

  countdown_timer #(
    .WIDTH     (WIDTH),
    .PRE_WIDTH (PRE_WIDTH)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .load_value_i (load_value_i),
    .reload_i     (reload_i),
    .prescale_i   (prescale_i),
    .stop_i       (stop_i),
    .count_o      (count_o),
    .busy_o       (busy_o),
    .expired_o    (expired_o)
  );

  // cyc == number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int               cyc;
    logic [WIDTH-1:0] count;
    logic             busy;
  } snap_t;

  snap_t snap_q[$];
  int    pulse_q[$];
  int    checks = 0;
  int    passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  task automatic push_snap(input int c, input int cnt, input bit busy);
    snap_t s;
    s.cyc   = c;
    s.count = cnt[WIDTH-1:0];
    s.busy  = busy;
    snap_q.push_back(s);
  endtask

  // Monitor: compares everything due at this cycle, away from the rising edge.
  snap_t ms;
  always @(negedge clk_i) begin
    while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
      ms = snap_q.pop_front();
      if (ms.cyc < cyc) begin
        check("snap_late", cyc, ms.cyc);
      end else begin
        check("count", int'(count_o), int'(ms.count));
        check("busy", int'(busy_o), int'(ms.busy));
        check("ready", int'(load_ready_o), int'(!ms.busy));
      end
    end
    if (expired_o === 1'b1) begin
      $display("expired pulse at cycle %0d count=%0d", cyc, count_o);
      if (pulse_q.size() == 0) check("unexpected_pulse", cyc, -1);
      else check("pulse_cycle", cyc, pulse_q.pop_front());
    end else if (pulse_q.size() > 0 && pulse_q[0] < cyc) begin
      check("missed_pulse", cyc, pulse_q.pop_front());
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Presents one load; h is the cycle count after the handshake edge.
  task automatic do_load(input int val, input bit rl, input int pre, output int h);
    load_value_i = val[WIDTH-1:0];
    reload_i     = rl;
    prescale_i   = pre[PRE_WIDTH-1:0];
    load_valid_i = 1'b1;
    h = cyc + 1;
    $display("load value=%0d reload=%0d prescale=%0d handshake_edge=%0d", val, rl, pre, h);
    @(posedge clk_i);
    #1;
    load_valid_i = 1'b0;
  endtask

  int h;

  initial begin
    reset_i      = 1'b1;
    load_valid_i = 1'b0;
    load_value_i = '0;
    reload_i     = 1'b0;
    prescale_i   = '0;
    stop_i       = 1'b0;
    push_snap(2, 0, 0);
    push_snap(3, 0, 0);
    wait_until(3);
    reset_i = 1'b0;
    wait_until(5);

    // Basic countdown: 5,4,3,2,1,0, pulse 5 edges after handshake.
    do_load(5, 0, 0, h);
    for (int k = 0; k <= 5; k++) push_snap(h + k, 5 - k, k < 5);
    pulse_q.push_back(h + 5);
    wait_until(h + 7);

    // Prescale 2: decrement every 3 cycles, pulse 9 edges after handshake.
    do_load(3, 0, 2, h);
    push_snap(h, 3, 1);     push_snap(h + 2, 3, 1);
    push_snap(h + 3, 2, 1); push_snap(h + 5, 2, 1);
    push_snap(h + 6, 1, 1); push_snap(h + 8, 1, 1);
    push_snap(h + 9, 0, 0);
    pulse_q.push_back(h + 9);
    wait_until(h + 11);

    // Auto-reload 4: pulses at +4, +8, +12; a load during RUN is ignored;
    // then stop at count 3.
    do_load(4, 1, 0, h);
    push_snap(h + 3, 1, 1);  push_snap(h + 4, 4, 1);
    push_snap(h + 7, 1, 1);  push_snap(h + 8, 4, 1);
    push_snap(h + 12, 4, 1); push_snap(h + 13, 3, 1);
    push_snap(h + 14, 3, 0);
    pulse_q.push_back(h + 4);
    pulse_q.push_back(h + 8);
    pulse_q.push_back(h + 12);
    wait_until(h + 5);
    load_value_i = 4'd9;
    load_valid_i = 1'b1;
    wait_until(h + 7);
    load_valid_i = 1'b0;
    wait_until(h + 13);
    stop_i = 1'b1;
    wait_until(h + 14);
    stop_i = 1'b0;
    wait_until(h + 16);

    // Zero load (even with reload): pulse on the handshake edge, stays IDLE.
    do_load(0, 1, 0, h);
    push_snap(h, 0, 0);
    push_snap(h + 1, 0, 0);
    pulse_q.push_back(h);
    wait_until(h + 3);

    // Stop at count 6: holds 6, no pulse; stop held in IDLE does nothing.
    do_load(10, 0, 0, h);
    push_snap(h + 4, 6, 1);
    push_snap(h + 5, 6, 0);
    push_snap(h + 8, 6, 0);
    wait_until(h + 4);
    stop_i = 1'b1;
    wait_until(h + 7);
    stop_i = 1'b0;
    wait_until(h + 9);

    // Reset mid-run, then reset together with a load request in IDLE.
    do_load(10, 0, 0, h);
    push_snap(h + 3, 7, 1);
    push_snap(h + 4, 0, 0);
    push_snap(h + 5, 0, 0);
    push_snap(h + 6, 0, 0);
    wait_until(h + 3);
    reset_i = 1'b1;
    wait_until(h + 4);
    load_value_i = 4'd7;
    load_valid_i = 1'b1;
    wait_until(h + 5);
    reset_i      = 1'b0;
    load_valid_i = 1'b0;
    wait_until(h + 7);

    // Full-scale load 15: 15 ticks to expiry.
    do_load(15, 0, 0, h);
    push_snap(h, 15, 1);
    push_snap(h + 14, 1, 1);
    push_snap(h + 15, 0, 0);
    pulse_q.push_back(h + 15);
    wait_until(h + 17);

    // Stop coincident with the terminal tick: no pulse, count holds 1.
    do_load(2, 0, 0, h);
    push_snap(h, 2, 1);
    push_snap(h + 1, 1, 1);
    push_snap(h + 2, 1, 0);
    push_snap(h + 4, 1, 0);
    wait_until(h + 1);
    stop_i = 1'b1;
    wait_until(h + 2);
    stop_i = 1'b0;
    wait_until(h + 6);

    check("pending_snaps", snap_q.size(), 0);
    check("pending_pulses", pulse_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_countdown_timer
